oddr_burst_arbiter: RTL

ODDR_BURST_ARBITER -- requirements
Module: oddr_burst_arbiter

---
 rtl/oddr_burst_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/oddr_burst_arbiter.sv
// oddr_burst_arbiter: round-robin two-requester burst serializer driving an ODDR/IOBUF pin pair
module oddr_burst_arbiter #(
  parameter int   WORD_W   = 8,
  parameter int   TURN_CYC = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_last,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              d1,
  output logic              d2,
  output logic              t,
  output logic              grant,
  output logic              busy
);
  localparam int HALF = WORD_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STALL, TURN} st_t;
  st_t st, nxt;
  logic [WORD_W-1:0] sr, word;
  logic [CW-1:0] cnt;
  logic [3:0] tcnt;
  logic last_r, lg, gsel, rdy, acc, fin;
  assign word = grant ? req_data1 : req_data0;
  assign fin = cnt == CW'(HALF - 1);
  assign gsel = &req_valid ? ~lg : req_valid[1];
  assign acc = rdy && req_valid[grant];
  assign req_ready = rdy ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy = st != IDLE;
  // state register
  always_ff @(posedge clk)
    st <= !rst_n ? IDLE : nxt;
  // next state and word-accept window
  always_comb begin
    nxt = st;
    rdy = 1'b0;
    case (st)
      IDLE:  nxt = |req_valid ? LOAD : IDLE;
      LOAD:  begin
        rdy = 1'b1;
        nxt = req_valid[grant] ? SHIFT : LOAD;
      end
      SHIFT: begin
        rdy = fin && !last_r;
        nxt = !fin ? SHIFT : last_r ? TURN : req_valid[grant] ? SHIFT : STALL;
      end
      STALL: begin
        rdy = 1'b1;
        nxt = req_valid[grant] ? SHIFT : STALL;
      end
      TURN:  nxt = tcnt == 4'(TURN_CYC - 1) ? IDLE : TURN;
      default: nxt = IDLE;
    endcase
  end
  // arbitration, shift register and registered pin outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t <= 1'b1;
      d1 <= IDLE_VAL;
      d2 <= IDLE_VAL;
      grant <= 1'b0;
      lg <= 1'b1;
      cnt <= '0;
      tcnt <= '0;
      sr <= '0;
      last_r <= 1'b0;
    end else begin
      if (st == IDLE && |req_valid) begin
        grant <= gsel;
        lg <= gsel;
      end
      if (acc) begin
        sr <= word >> 2;
        d1 <= word[0];
        d2 <= word[1];
        t <= 1'b0;
        cnt <= '0;
        last_r <= req_last[grant];
      end else if (st == SHIFT && !fin) begin
        sr <= sr >> 2;
        d1 <= sr[0];
        d2 <= sr[1];
        cnt <= cnt + 1'b1;
      end else if (st == SHIFT) begin
        d1 <= IDLE_VAL;
        d2 <= IDLE_VAL;
        t <= last_r;
        tcnt <= '0;
      end else if (st == TURN) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
endmodule
